// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and shadow-stage bundles
// for the D-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_CMCO    = 6'h3f;

  localparam logic [1:0] SEL_NONE   = 2'd0;
  localparam logic [1:0] SEL_NEAR   = 2'd1;
  localparam logic [1:0] SEL_FAR    = 2'd2;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  typedef struct packed {
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } decode_t;

  function automatic logic hit(
    input logic [4:0] a3,
    input logic [4:0] src
  );
    return (src != 5'd0) && (a3 == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_tuse.sv
// Decodes the D-stage IR into operand use
// times, masked source indices and Tnew.
module hazard_scoreboard_tuse
  import hazard_scoreboard_pkg::*;
#(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic       special;
  logic       addu, subu, cmco, jr;
  logic       ori, lui, lw, sw;
  logic       beq, jal;
  logic       unused_shamt;

  assign op      = instr[31:26];
  assign fn      = instr[5:0];
  assign f_rs    = instr[25:21];
  assign f_rt    = instr[20:16];
  assign f_rd    = instr[15:11];
  assign special = (op == OP_SPECIAL);

  assign addu = special && (fn == FN_ADDU);
  assign subu = special && (fn == FN_SUBU);
  assign cmco = special && (fn == FN_CMCO);
  assign jr   = special && (fn == FN_JR);
  assign ori  = (op == OP_ORI);
  assign lui  = (op == OP_LUI);
  assign lw   = (op == OP_LW);
  assign sw   = (op == OP_SW);
  assign beq  = (op == OP_BEQ);
  assign jal  = (op == OP_JAL);

  assign unused_shamt = ^instr[10:6];

  // Per-class use times, destination and
  // result latency; unused sources read as 0.
  always_comb begin
    dec = '0;
    unique case (1'b1)
      addu, subu, cmco: begin
        dec.rs      = f_rs;
        dec.rt      = f_rt;
        dec.tuse_rs = 2'd1;
        dec.tuse_rt = 2'd1;
        dec.a3      = f_rd;
        dec.tnew    = 2'd1;
      end
      ori: begin
        dec.rs      = f_rs;
        dec.tuse_rs = 2'd1;
        dec.a3      = f_rt;
        dec.tnew    = 2'd1;
      end
      lui: begin
        dec.a3      = f_rt;
        dec.tnew    = 2'd1;
      end
      lw: begin
        dec.rs      = f_rs;
        dec.tuse_rs = 2'd1;
        dec.a3      = f_rt;
        dec.tnew    = 2'd2;
      end
      sw: begin
        dec.rs      = f_rs;
        dec.rt      = f_rt;
        dec.tuse_rs = 2'd1;
        dec.tuse_rt = 2'd2;
      end
      beq: begin
        dec.rs      = f_rs;
        dec.rt      = f_rt;
      end
      jr: begin
        dec.rs      = f_rs;
      end
      jal: begin
        dec.a3      = RA_IDX;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Consumer-side hazard unit: E/M/W shadow
// stages, stall compare and forward selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  decode_t dec;
  stage_t  e_q, e_d;
  stage_t  m_q, m_d;
  stage_t  w_q, w_d;
  logic    unused_bits;

  hazard_scoreboard_tuse #(
    .RA_IDX (RA_IDX)
  ) u_tuse (
    .instr (instr_d),
    .dec   (dec)
  );

  assign unused_bits = ^{w_q.tnew, w_q.rs,
                         w_q.rt, m_q.rs};

  // Stage advance: bubble into E on stall,
  // Tnew counts down toward 0.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.a3   = dec.a3;
      e_d.tnew = dec.tnew;
      e_d.rs   = dec.rs;
      e_d.rt   = dec.rt;
    end
    m_d = e_q;
    if (e_q.tnew != 2'd0)
      m_d.tnew = e_q.tnew - 2'd1;
    w_d      = m_q;
    w_d.tnew = 2'd0;
  end

  // Shadow registers for the E/M/W occupants.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Stall when a source is needed before the
  // E or M producer can deliver it.
  always_comb begin
    stall = 1'b0;
    if (hit(e_q.a3, dec.rs) &&
        dec.tuse_rs < e_q.tnew)
      stall = 1'b1;
    if (hit(e_q.a3, dec.rt) &&
        dec.tuse_rt < e_q.tnew)
      stall = 1'b1;
    if (hit(m_q.a3, dec.rs) &&
        dec.tuse_rs < m_q.tnew)
      stall = 1'b1;
    if (hit(m_q.a3, dec.rt) &&
        dec.tuse_rt < m_q.tnew)
      stall = 1'b1;
  end

  // D selects: nearest match wins; a pending
  // near producer blocks older data.
  always_comb begin
    fwd_rs_d = SEL_NONE;
    fwd_rt_d = SEL_NONE;
    if (hit(e_q.a3, dec.rs)) begin
      if (e_q.tnew == 2'd0)
        fwd_rs_d = SEL_NEAR;
    end else if (hit(m_q.a3, dec.rs) &&
                 m_q.tnew == 2'd0) begin
      fwd_rs_d = SEL_FAR;
    end
    if (hit(e_q.a3, dec.rt)) begin
      if (e_q.tnew == 2'd0)
        fwd_rt_d = SEL_NEAR;
    end else if (hit(m_q.a3, dec.rt) &&
                 m_q.tnew == 2'd0) begin
      fwd_rt_d = SEL_FAR;
    end
  end

  // E and M selects from the later stages.
  always_comb begin
    fwd_rs_e = SEL_NONE;
    fwd_rt_e = SEL_NONE;
    if (hit(m_q.a3, e_q.rs)) begin
      if (m_q.tnew == 2'd0)
        fwd_rs_e = SEL_NEAR;
    end else if (hit(w_q.a3, e_q.rs)) begin
      fwd_rs_e = SEL_FAR;
    end
    if (hit(m_q.a3, e_q.rt)) begin
      if (m_q.tnew == 2'd0)
        fwd_rt_e = SEL_NEAR;
    end else if (hit(w_q.a3, e_q.rt)) begin
      fwd_rt_e = SEL_FAR;
    end
    fwd_rt_m = hit(w_q.a3, m_q.rt);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for the
// hazard scoreboard.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  typedef struct packed {
    logic       st;
    logic [1:0] rsd;
    logic [1:0] rtd;
    logic [1:0] rse;
    logic [1:0] rte;
    logic       rtm;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic        fwd_rt_m;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  hazard_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .instr_d  (instr_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtyp(
    input logic [5:0] fn,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd
  );
    return {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ityp(
    input logic [5:0] op,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return {op, rs, rt, 16'h0007};
  endfunction

  function automatic exp_t mk(
    input logic       st,
    input logic [1:0] rsd,
    input logic [1:0] rtd,
    input logic [1:0] rse,
    input logic [1:0] rte,
    input logic       rtm
  );
    exp_t e;
    e = '{st, rsd, rtd, rse, rte, rtm};
    return e;
  endfunction

  // Drive D for one cycle, queue the expected
  // outputs, then compare mid-cycle.
  task automatic step(
    input string       tag,
    input logic [31:0] ir,
    input logic        rst,
    input exp_t        e
  );
    exp_t x;
    @(posedge clk);
    #1;
    instr_d = ir;
    reset   = rst;
    sb_q.push_back(e);
    @(negedge clk);
    x = sb_q.pop_front();
    check({tag, ".stall"}, int'(stall), int'(x.st));
    check({tag, ".rs_d"}, int'(fwd_rs_d), int'(x.rsd));
    check({tag, ".rt_d"}, int'(fwd_rt_d), int'(x.rtd));
    check({tag, ".rs_e"}, int'(fwd_rs_e), int'(x.rse));
    check({tag, ".rt_e"}, int'(fwd_rt_e), int'(x.rte));
    check({tag, ".rt_m"}, int'(fwd_rt_m), int'(x.rtm));
  endtask

  logic [31:0] nop;
  logic [31:0] lw1;
  logic [31:0] add_2_13;
  logic [31:0] jal_i;
  logic [31:0] jr31;

  initial begin
    checks  = 0;
    errors  = 0;
    nop     = 32'd0;
    lw1     = ityp(OP_LW, 5'd0, 5'd1);
    add_2_13 = rtyp(FN_ADDU, 5'd1, 5'd3, 5'd2);
    jal_i   = {OP_JAL, 26'd4};
    jr31    = rtyp(FN_JR, 5'd31, 5'd0, 5'd0);
    reset   = 1'b1;
    instr_d = nop;
    repeat (2) @(posedge clk);

    step("rst", nop, 0, mk(0,0,0,0,0,0));

    step("ld_a", lw1, 0, mk(0,0,0,0,0,0));
    step("use_a", add_2_13, 0, mk(1,0,0,0,0,0));
    step("use_b", add_2_13, 0, mk(0,0,0,0,0,0));
    step("fw_w", nop, 0, mk(0,0,0,2,0,0));
    step("fw_dm",
         rtyp(FN_ADDU, 5'd2, 5'd2, 5'd4), 0,
         mk(0,2,2,0,0,0));
    step("fw_w2", nop, 0, mk(0,0,0,2,2,0));

    step("ld_b", lw1, 0, mk(0,0,0,0,0,0));
    step("beq_0",
         ityp(OP_BEQ, 5'd1, 5'd1), 0,
         mk(1,0,0,0,0,0));
    step("beq_1",
         ityp(OP_BEQ, 5'd1, 5'd1), 0,
         mk(1,0,0,0,0,0));
    step("beq_2",
         ityp(OP_BEQ, 5'd1, 5'd1), 0,
         mk(0,0,0,0,0,0));

    step("ori", ityp(OP_ORI, 5'd0, 5'd5), 0,
         mk(0,0,0,0,0,0));
    step("sw_d", ityp(OP_SW, 5'd6, 5'd5), 0,
         mk(0,0,0,0,0,0));
    step("sw_e", nop, 0, mk(0,0,0,0,1,0));
    step("sw_m", nop, 0, mk(0,0,0,0,0,1));

    step("jal", jal_i, 0, mk(0,0,0,0,0,0));
    step("jr_d", jr31, 0, mk(0,1,0,0,0,0));
    step("jr_e", nop, 0, mk(0,0,0,1,0,0));

    step("r0_w",
         rtyp(FN_ADDU, 5'd1, 5'd2, 5'd0), 0,
         mk(0,0,0,0,0,0));
    step("r0_u",
         rtyp(FN_ADDU, 5'd0, 5'd0, 5'd3), 0,
         mk(0,0,0,0,0,0));
    step("r0_e", nop, 0, mk(0,0,0,0,0,0));

    step("lui_a", ityp(OP_LUI, 5'd0, 5'd7), 0,
         mk(0,0,0,0,0,0));
    step("lui_b", ityp(OP_LUI, 5'd0, 5'd7), 0,
         mk(0,0,0,0,0,0));
    step("blk_d",
         rtyp(FN_ADDU, 5'd7, 5'd0, 5'd8), 0,
         mk(0,0,0,0,0,0));
    step("m_ovr_w", nop, 0, mk(0,0,0,1,0,0));

    step("cmco",
         rtyp(FN_CMCO, 5'd7, 5'd7, 5'd9), 0,
         mk(0,0,0,0,0,0));
    step("subu",
         rtyp(FN_SUBU, 5'd9, 5'd9, 5'd10), 0,
         mk(0,0,0,0,0,0));
    step("sub_e", nop, 0, mk(0,0,0,1,1,0));

    step("ld_c", lw1, 0, mk(0,0,0,0,0,1));
    step("rst_hi", add_2_13, 1, mk(1,0,0,0,0,0));
    step("rst_lo", add_2_13, 0, mk(0,0,0,0,0,0));

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
